key_schedule: RTL and testbench

KEY_SCHEDULE -- requirements
Module: key_schedule

---
 rtl/key_schedule.sv | 152 +++++++++++++++
 tb/tb_key_schedule.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/key_schedule.sv
// SPECK-style round-key expansion with registered round-key read port.
// Optional macro KEY_SCHEDULE_REVERSE_READ_EN reverses the read address (decryption order).
`ifndef BLOCK_SIZE
`define BLOCK_SIZE 16
`endif
`ifndef KEY_SIZE
`define KEY_SIZE 32
`endif
`ifndef ROUND_COUNT
`define ROUND_COUNT 22
`endif
`ifndef SHIFT_WIDTH_P0
`define SHIFT_WIDTH_P0 7
`endif
`ifndef SHIFT_WIDTH_P1
`define SHIFT_WIDTH_P1 2
`endif

module key_schedule (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [2*`KEY_SIZE-1:0]    key,
   input  logic                      signal_start,
   output logic                      finished,
   output logic                      busy,
   input  logic [4:0]                round_index,
   output logic [`BLOCK_SIZE-1:0]    subkey,
   output logic [1:0]                state_response
);
   localparam int N     = `BLOCK_SIZE;
   localparam int RC    = `ROUND_COUNT;
   localparam int ALPHA = `SHIFT_WIDTH_P0;
   localparam int BETA  = `SHIFT_WIDTH_P1;

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, EXPAND = 2'd2, DONE = 2'd3} state_t;

   state_t                  state_reg, state_next;
   logic [2*`KEY_SIZE-1:0]  key_reg;
   logic [N-1:0]            k_reg;
   logic [N-1:0]            l_reg [3];
   logic [4:0]              i_reg;
   logic [N-1:0]            storage [RC];

   logic [N-1:0]            l_rot, k_rot, l_new, k_next;
   logic                    wr_en;
   logic [4:0]              wr_addr;
   logic [N-1:0]            wr_data;
   logic [4:0]              rd_addr;

   assign l_rot  = (l_reg[0] >> ALPHA) | (l_reg[0] << (N - ALPHA));
   assign k_rot  = (k_reg << BETA) | (k_reg >> (N - BETA));
   assign l_new  = (k_reg + l_rot) ^ N'(i_reg);
   assign k_next = k_rot ^ l_new;

   always_comb begin
      state_next = state_reg;
      wr_en      = 1'b0;
      wr_addr    = i_reg + 5'd1;
      wr_data    = k_next;
      case (state_reg)
         IDLE, DONE: if (signal_start) state_next = LOAD;
         LOAD: begin
            state_next = EXPAND;
            wr_en      = 1'b1;
            wr_addr    = '0;
            wr_data    = key_reg[N-1:0];
         end
         EXPAND: begin
            // The final iteration only retires the pipeline; its k_{i+1} has no slot.
            wr_en = (int'(i_reg) + 1 < RC);
            if (int'(i_reg) == RC - 1) state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         finished  <= 1'b0;
         busy      <= 1'b0;
         key_reg   <= '0;
         k_reg     <= '0;
         l_reg[0]  <= '0;
         l_reg[1]  <= '0;
         l_reg[2]  <= '0;
         i_reg     <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE, DONE: begin
               if (signal_start) begin
                  key_reg  <= key;
                  finished <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            LOAD: begin
               k_reg    <= key_reg[N-1:0];
               l_reg[0] <= key_reg[2*N-1:N];
               l_reg[1] <= key_reg[3*N-1:2*N];
               l_reg[2] <= key_reg[4*N-1:3*N];
               i_reg    <= '0;
            end
            EXPAND: begin
               k_reg    <= k_next;
               l_reg[0] <= l_reg[1];
               l_reg[1] <= l_reg[2];
               l_reg[2] <= l_new;
               i_reg    <= i_reg + 5'd1;
               if (state_next == DONE) begin
                  finished <= 1'b1;
                  busy     <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Register file is cleared by reset, so each entry is its own flop bank.
   genvar gi;
   generate
      for (gi = 0; gi < RC; gi++) begin : g_store
         logic [N-1:0] entry_reg;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
               entry_reg <= '0;
            else if (wr_en && wr_addr == 5'(gi))
               entry_reg <= wr_data;
         end
         assign storage[gi] = entry_reg;
      end
   endgenerate

`ifdef KEY_SCHEDULE_REVERSE_READ_EN
   assign rd_addr = 5'(RC - 1) - round_index;
`else
   assign rd_addr = round_index;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         subkey <= '0;
      else if (int'(round_index) >= RC)
         subkey <= '0;
      else
         subkey <= storage[rd_addr];
   end

   assign state_response = state_reg;
endmodule

// File: tb/tb_key_schedule.sv
// Bench for key_schedule: SPECK32/64 key-schedule model plus directed timing/reset checks.
// Honours KEY_SCHEDULE_REVERSE_READ_EN the same way as the design.
`timescale 1ns/1ps
module tb_key_schedule;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [63:0] key = '0;
   logic        signal_start = 1'b0;
   logic        finished, busy;
   logic [4:0]  round_index = '0;
   logic [15:0] subkey;
   logic [1:0]  state_response;

   int compared = 0;
   int mismatched = 0;

   logic [15:0] model_rk [22];
   logic        model_valid = 1'b0;
   logic [4:0]  idx_q = '0;

`ifdef KEY_SCHEDULE_REVERSE_READ_EN
   localparam int IDX_K0 = 21, IDX_K1 = 20;
`else
   localparam int IDX_K0 = 0, IDX_K1 = 1;
`endif

   key_schedule dut (
      .clk(clk), .reset_n(reset_n), .key(key), .signal_start(signal_start),
      .finished(finished), .busy(busy), .round_index(round_index),
      .subkey(subkey), .state_response(state_response)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] ror16(input logic [15:0] x, input int a);
      logic [31:0] d;
      d = {x, x} >> a;
      return d[15:0];
   endfunction

   // Textbook SPECK32/64 key schedule: l[i+3] = (k_i + ROR(l_i,7)) ^ i; k_{i+1} = ROL(k_i,2) ^ l[i+3].
   task automatic model_expand(input logic [63:0] kk);
      logic [15:0] l [24];
      logic [15:0] k;
      k    = kk[15:0];
      l[0] = kk[31:16];
      l[1] = kk[47:32];
      l[2] = kk[63:48];
      model_rk[0] = k;
      for (int i = 0; i < 21; i++) begin
         l[i+3] = (k + ror16(l[i], 7)) ^ 16'(i);
         k = ror16(k, 14) ^ l[i+3];
         model_rk[i+1] = k;
      end
   endtask

   function automatic logic [15:0] exp_read(input logic [4:0] idx);
      if (int'(idx) >= 22) return 16'h0;
`ifdef KEY_SCHEDULE_REVERSE_READ_EN
      return model_rk[21 - int'(idx)];
`else
      return model_rk[idx];
`endif
   endfunction

   // Scoreboard: whenever the DUT claims all keys valid, subkey must match the model.
   always @(posedge clk) idx_q <= round_index;
   always @(negedge clk) begin
      if (reset_n && finished && model_valid)
         chk($sformatf("scoreboard idx=%0d", idx_q), {16'h0, subkey}, {16'h0, exp_read(idx_q)});
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic read_idx(input int idx, input string name, input logic [15:0] exp);
      round_index = 5'(idx);
      step();
      chk(name, {16'h0, subkey}, {16'h0, exp});
      $display("read idx=%0d subkey=0x%04h", idx, subkey);
   endtask

   // Starts an expansion; abort_at>0 asserts reset after that many edges.
   task automatic expand(input logic [63:0] kk, input int abort_at);
      model_valid = 1'b0;
      key = kk;
      signal_start = 1'b1;
      step();
      signal_start = 1'b0;
      key = ~kk;
      chk("accept busy", {31'h0, busy}, 32'h1);
      chk("accept finished", {31'h0, finished}, 32'h0);
      chk("accept state LOAD", {30'h0, state_response}, 32'h1);
      if (abort_at == 0) begin
         model_expand(kk);
         model_valid = 1'b1;
      end
      for (int e = 1; e <= 23; e++) begin
         step();
         if (e == 1) chk("state EXPAND", {30'h0, state_response}, 32'h2);
         if (e == 4) begin
            signal_start = 1'b1;
            key = 64'hdead_beef_cafe_f00d;
         end
         if (e == 5) signal_start = 1'b0;
         if (e == abort_at) begin
            reset_n = 1'b0;
            #1;
            chk("abort finished", {31'h0, finished}, 32'h0);
            chk("abort busy", {31'h0, busy}, 32'h0);
            chk("abort subkey", {16'h0, subkey}, 32'h0);
            chk("abort state IDLE", {30'h0, state_response}, 32'h0);
            $display("reset asserted at expansion edge %0d", e);
            break;
         end
         if (e == 22) begin
            chk("finished low at edge 22", {31'h0, finished}, 32'h0);
            chk("busy high at edge 22", {31'h0, busy}, 32'h1);
         end
         if (e == 23) begin
            chk("finished at edge 23", {31'h0, finished}, 32'h1);
            chk("busy low at edge 23", {31'h0, busy}, 32'h0);
            chk("state DONE", {30'h0, state_response}, 32'h3);
         end
      end
      $display("expansion key=0x%016h abort_at=%0d finished=%0b", kk, abort_at, finished);
   endtask

   initial begin
      round_index = 5'd1;
      #3;
      chk("reset finished", {31'h0, finished}, 32'h0);
      chk("reset busy", {31'h0, busy}, 32'h0);
      chk("reset subkey", {16'h0, subkey}, 32'h0);
      chk("reset state", {30'h0, state_response}, 32'h0);
      step();
      step();
      reset_n = 1'b1;
      step();
      chk("idle after reset", {30'h0, state_response}, 32'h0);

      // Test vector from the SPECK paper, with a stray start pulse mid-expansion.
      expand(64'h1918_1110_0908_0100, 0);
      read_idx(IDX_K0, "k0 literal", 16'h0100);
      read_idx(IDX_K1, "k1 literal", 16'h1512);
      for (int i = 0; i < 32; i++) begin
         round_index = 5'(i);
         step();
      end
      read_idx(22, "index 22 zero", 16'h0000);
      read_idx(31, "index 31 zero", 16'h0000);
      chk("still DONE", {30'h0, state_response}, 32'h3);

      // Restart from DONE with another key.
      expand(64'h0123_4567_89ab_cdef, 0);
      for (int i = 0; i < 32; i++) begin
         round_index = 5'(31 - i);
         step();
      end

      // Abort mid-expansion; storage must be wiped and the block must idle.
      expand(64'h1918_1110_0908_0100, 10);
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) step();
      chk("idle after abort", {30'h0, state_response}, 32'h0);
      chk("no finish after abort", {31'h0, finished}, 32'h0);
      read_idx(1, "index 1 cleared", 16'h0000);
      read_idx(IDX_K0, "k0 slot cleared", 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
